intt_result_drain: RTL and testbench



---
 rtl/intt_result_drain_pkg.sv | 25 ++
 rtl/intt_result_drain_mod_canon.sv | 21 ++
 rtl/intt_result_drain.sv | 136 +++++++++++++
 tb/tb_intt_result_drain.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intt_result_drain_pkg.sv
// Shared types and helpers for the INTT result drain stage.
// Optional build macro INTT_DRAIN_BITREV_EN selects bit-reversed drain order.
package intt_result_drain_pkg;

   localparam int DEF_N = 17;
   localparam int DEF_D = 8;
   localparam int DEF_Q = 65537;
   localparam int IDXW  = $clog2(DEF_D);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // Reverse the low w bits of v; upper bits of the result are zero.
   function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int unsigned w);
      logic [31:0] r;
      r = 32'd0;
      for (int unsigned i = 0; i < w; i++) begin
         r = r | (((v >> i) & 32'd1) << (w - 32'd1 - i));
      end
      return r;
   endfunction

endpackage

// File: rtl/intt_result_drain_mod_canon.sv
// Conditional subtract that folds a coefficient in [0,2Q) into [0,Q).
module mod_canon #(
   parameter int N = 17,
   parameter int Q = 65537
) (
   input  logic [N-1:0] c_i,
   output logic [N-1:0] r_o
);

   localparam logic [N-1:0] Q_N = N'(Q);

   // Single compare/subtract; inputs at or above 2Q still only lose one Q.
   always_comb begin
      if (c_i >= Q_N) begin
         r_o = c_i - Q_N;
      end else begin
         r_o = c_i;
      end
   end

endmodule

// File: rtl/intt_result_drain.sv
// Captures a parallel INTT result vector, canonicalises it and streams it out
// one coefficient per beat. Build macro INTT_DRAIN_BITREV_EN: bit-reversed order.
module intt_result_drain
   import intt_result_drain_pkg::*;
#(
   parameter  int N  = DEF_N,
   parameter  int D  = DEF_D,
   parameter  int Q  = DEF_Q,
   localparam int IW = $clog2(D)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic [D*N-1:0] in_data,
   output logic           in_ready,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_data,
   output logic [IW-1:0]  out_idx,
   output logic           out_last,
   output logic           busy
);

   localparam logic [IW-1:0] LAST_PTR = IW'(D - 1);

   state_e         state_q, state_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [IW-1:0]  order_s;
   logic [N-1:0]   coef_q  [D];
   logic [N-1:0]   coef_d  [D];
   logic [N-1:0]   canon_s [D];
   logic           accept_beat_s;
   logic           last_beat_s;
   logic           in_ready_s;
   logic           capture_s;

   for (genvar k = 0; k < D; k++) begin : g_canon
      mod_canon #(
         .N (N),
         .Q (Q)
      ) u_canon (
         .c_i (in_data[N*k +: N]),
         .r_o (canon_s[k])
      );
   end

`ifdef INTT_DRAIN_BITREV_EN
   assign order_s = IW'(bit_reverse(32'(ptr_q), IW));
`else
   assign order_s = ptr_q;
`endif

   // Handshake decode; a new vector may enter on the cycle the last beat leaves.
   always_comb begin
      accept_beat_s = (state_q == DRAIN) && out_ready;
      last_beat_s   = accept_beat_s && (ptr_q == LAST_PTR);
      in_ready_s    = (state_q == IDLE) || last_beat_s;
      capture_s     = in_valid && in_ready_s;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (capture_s) begin
               state_d = DRAIN;
            end else begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (last_beat_s && !capture_s) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Beat pointer and vector buffer; the pointer wraps only on the last beat.
   always_comb begin
      if (capture_s) begin
         ptr_d = '0;
      end else if (accept_beat_s) begin
         ptr_d = ptr_q + IW'(1);
      end else begin
         ptr_d = ptr_q;
      end
      for (int k = 0; k < D; k++) begin
         if (capture_s) begin
            coef_d[k] = canon_s[k];
         end else begin
            coef_d[k] = coef_q[k];
         end
      end
   end

   // State, pointer and buffer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         for (int k = 0; k < D; k++) begin
            coef_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         for (int k = 0; k < D; k++) begin
            coef_q[k] <= coef_d[k];
         end
      end
   end

   // Output decode; everything reads zero outside DRAIN.
   always_comb begin
      in_ready = in_ready_s;
      if (state_q == DRAIN) begin
         out_valid = 1'b1;
         out_data  = coef_q[order_s];
         out_idx   = order_s;
         out_last  = (ptr_q == LAST_PTR);
         busy      = 1'b1;
      end else begin
         out_valid = 1'b0;
         out_data  = '0;
         out_idx   = '0;
         out_last  = 1'b0;
         busy      = 1'b0;
      end
   end

endmodule

// File: tb/tb_intt_result_drain.sv
// Self-checking bench for intt_result_drain: directed scenarios plus a
// randomized run scored against a queue-based model of the output stream.
module tb_intt_result_drain;

   localparam int N  = 17;
   localparam int D  = 8;
   localparam int Q  = 65537;
   localparam int IW = $clog2(D);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic [D*N-1:0] in_data = '0;
   logic           in_ready;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [N-1:0]   out_data;
   logic [IW-1:0]  out_idx;
   logic           out_last;
   logic           busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int idx;
      int data;
      bit last;
   } beat_t;

   beat_t exp_q[$];

   intt_result_drain #(.N(N), .D(D), .Q(Q)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Index of the coefficient emitted on beat p.
   function automatic int ref_order(int p);
      int r;
      r = p;
`ifdef INTT_DRAIN_BITREV_EN
      r = 0;
      for (int b = 0; b < IW; b++) r = r * 2 + ((p >> b) & 1);
`endif
      return r;
   endfunction

   function automatic int ref_canon(int c);
      return (c >= Q) ? c - Q : c;
   endfunction

   function automatic int coef_of(logic [D*N-1:0] v, int k);
      return int'(v[N*k +: N]);
   endfunction

   function automatic logic [D*N-1:0] rand_vec();
      logic [D*N-1:0] v;
      for (int k = 0; k < D; k++) v[N*k +: N] = N'($urandom_range(0, (1 << N) - 1));
      return v;
   endfunction

   function automatic int exp_data(logic [D*N-1:0] v, int p);
      return ref_canon(coef_of(v, ref_order(p)));
   endfunction

   // Drive inputs just after the falling edge; outputs are read 1 time unit later.
   task automatic step(input logic v, input logic [D*N-1:0] d, input logic ordy);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      checks++; if (out_idx !== '0) begin failures++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
      checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_single_vector();
      int vals [D] = '{0, 1, 65536, 65537, 65538, 131071, 5, 7};
      int canon[D] = '{0, 1, 65536, 0, 1, 65534, 5, 7};
      logic [D*N-1:0] vec;
      int k;
      for (int i = 0; i < D; i++) vec[N*i +: N] = N'(vals[i]);
      step(1'b1, vec, 1'b1);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_accept in_ready=%b exp=1", in_ready); end
      for (int b = 0; b < D; b++) begin
         step(1'b0, '0, 1'b1);
         k = ref_order(b);
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid beat=%0d got=%b exp=1", b, out_valid); end
         checks++; if (int'(out_data) !== canon[k]) begin failures++; $display("FAIL single_data beat=%0d got=%0d exp=%0d", b, out_data, canon[k]); end
         checks++; if (int'(out_idx) !== k) begin failures++; $display("FAIL single_idx beat=%0d got=%0d exp=%0d", b, out_idx, k); end
         checks++; if (out_last !== (b == D - 1)) begin failures++; $display("FAIL single_last beat=%0d got=%b exp=%b", b, out_last, (b == D - 1)); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy beat=%0d got=%b exp=1", b, busy); end
         if (b == D - 1) begin
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_last got=%b exp=1", in_ready); end
         end
      end
      step(1'b0, '0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_idle_after got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_order();
      logic [D*N-1:0] vec;
      int k;
      for (int i = 0; i < D; i++) vec[N*i +: N] = N'(10 + i);
      step(1'b1, vec, 1'b1);
      for (int b = 0; b < D; b++) begin
         step(1'b0, '0, 1'b1);
         k = ref_order(b);
         checks++; if (int'(out_idx) !== k) begin failures++; $display("FAIL order_idx beat=%0d got=%0d exp=%0d", b, out_idx, k); end
         checks++; if (int'(out_data) !== 10 + k) begin failures++; $display("FAIL order_data beat=%0d got=%0d exp=%0d", b, out_data, 10 + k); end
         checks++; if (out_last !== (b == D - 1)) begin failures++; $display("FAIL order_last beat=%0d got=%b", b, out_last); end
      end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [D*N-1:0] vec;
      logic           r;
      logic           stalled;
      logic [N-1:0]   prev_data;
      logic [IW-1:0]  prev_idx;
      int             beats;
      int             cyc;
      vec = rand_vec();
      step(1'b1, vec, 1'b1);
      beats = 0; cyc = 0; stalled = 1'b0; prev_data = '0; prev_idx = '0;
      while (beats < D && cyc < 64) begin
         r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         step(1'b0, '0, r);
         checks++;
         if (out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", cyc, out_valid);
         end else begin
            if (stalled) begin
               checks++; if (out_data !== prev_data || out_idx !== prev_idx) begin failures++; $display("FAIL bp_hold cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, out_data, out_idx, prev_data, prev_idx); end
            end
            checks++; if (int'(out_data) !== exp_data(vec, beats)) begin failures++; $display("FAIL bp_data beat=%0d got=%0d exp=%0d", beats, out_data, exp_data(vec, beats)); end
            checks++; if (int'(out_idx) !== ref_order(beats)) begin failures++; $display("FAIL bp_idx beat=%0d got=%0d exp=%0d", beats, out_idx, ref_order(beats)); end
            if (r) beats++;
         end
         stalled = !r; prev_data = out_data; prev_idx = out_idx;
         cyc++;
      end
      checks++; if (beats != D) begin failures++; $display("FAIL bp_beat_count got=%0d exp=%0d", beats, D); end
      step(1'b0, '0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra_beat got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [D*N-1:0] va, vb, src;
      logic           v;
      int             p;
      va = rand_vec(); vb = rand_vec();
      step(1'b1, va, 1'b1);
      for (int i = 0; i < 2 * D; i++) begin
         v = (i == D - 1);
         step(v, v ? vb : '0, 1'b1);
         src = (i < D) ? va : vb;
         p = i % D;
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid beat=%0d got=%b exp=1", i, out_valid); end
         checks++; if (int'(out_data) !== exp_data(src, p)) begin failures++; $display("FAIL b2b_data beat=%0d got=%0d exp=%0d", i, out_data, exp_data(src, p)); end
         checks++; if (int'(out_idx) !== ref_order(p)) begin failures++; $display("FAIL b2b_idx beat=%0d got=%0d exp=%0d", i, out_idx, ref_order(p)); end
         checks++; if (out_last !== (p == D - 1)) begin failures++; $display("FAIL b2b_last beat=%0d got=%b", i, out_last); end
         if (i == D - 1) begin
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
         end
      end
      step(1'b0, '0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid_drain();
      logic [D*N-1:0] va, vb;
      va = rand_vec(); vb = rand_vec();
      step(1'b1, va, 1'b1);
      for (int b = 0; b < 3; b++) begin
         step(1'b0, '0, 1'b1);
         checks++; if (int'(out_data) !== exp_data(va, b)) begin failures++; $display("FAIL rmd_pre_data beat=%0d got=%0d exp=%0d", b, out_data, exp_data(va, b)); end
      end
      rst = 1'b1;
      step(1'b0, '0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmd_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmd_busy got=%b exp=0", busy); end
      checks++; if (out_idx !== '0 || out_data !== '0 || out_last !== 1'b0) begin failures++; $display("FAIL rmd_outputs got=%0d/%0d/%b exp=0/0/0", out_idx, out_data, out_last); end
      rst = 1'b0;
      step(1'b0, '0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmd_no_beats got=%b exp=0", out_valid); end
      step(1'b1, vb, 1'b1);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmd_in_ready got=%b exp=1", in_ready); end
      for (int b = 0; b < D; b++) begin
         step(1'b0, '0, 1'b1);
         checks++; if (int'(out_idx) !== ref_order(b)) begin failures++; $display("FAIL rmd_idx beat=%0d got=%0d exp=%0d", b, out_idx, ref_order(b)); end
         checks++; if (int'(out_data) !== exp_data(vb, b)) begin failures++; $display("FAIL rmd_data beat=%0d got=%0d exp=%0d", b, out_data, exp_data(vb, b)); end
      end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_stall_last();
      logic [D*N-1:0] va, vb;
      va = rand_vec(); vb = rand_vec();
      step(1'b1, va, 1'b1);
      for (int b = 0; b < D - 1; b++) step(1'b0, '0, 1'b1);
      for (int s = 0; s < 3; s++) begin
         step(1'b1, vb, 1'b0);
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", s, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin failures++; $display("FAIL stall_last cyc=%0d got=%b/%b exp=1/1", s, out_valid, out_last); end
         checks++; if (int'(out_data) !== exp_data(va, D - 1)) begin failures++; $display("FAIL stall_data cyc=%0d got=%0d exp=%0d", s, out_data, exp_data(va, D - 1)); end
      end
      step(1'b1, vb, 1'b1);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", in_ready); end
      for (int b = 0; b < D; b++) begin
         step(1'b0, '0, 1'b1);
         checks++; if (out_valid !== 1'b1 || int'(out_data) !== exp_data(vb, b)) begin failures++; $display("FAIL stall_b_data beat=%0d got=%b/%0d exp=1/%0d", b, out_valid, out_data, exp_data(vb, b)); end
      end
      step(1'b0, '0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_idle_after got=%b exp=0", out_valid); end
   endtask

   task automatic test_random();
      logic [D*N-1:0] d;
      logic           v, r, exp_rdy;
      int             n;
      beat_t          bt;
      exp_q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         v = (cyc < 560) && ($urandom_range(0, 2) != 0);
         r = (cyc >= 560) || ($urandom_range(0, 3) != 0);
         d = rand_vec();
         step(v, d, r);
         n = exp_q.size();
         exp_rdy = (n == 0) || (n == 1 && r);
         checks++; if (out_valid !== (n != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (n != 0)); end
         checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
         checks++; if (busy !== (n != 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, (n != 0)); end
         if (n != 0) begin
            bt = exp_q[0];
            checks++; if (int'(out_data) !== bt.data || int'(out_idx) !== bt.idx || out_last !== bt.last) begin
               failures++; $display("FAIL rnd_beat cyc=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", cyc, out_data, out_idx, out_last, bt.data, bt.idx, bt.last);
            end
            if (r) void'(exp_q.pop_front());
         end
         if (v && exp_rdy) begin
            for (int p = 0; p < D; p++) begin
               bt.idx = ref_order(p); bt.data = exp_data(d, p); bt.last = (p == D - 1);
               exp_q.push_back(bt);
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_drain_timeout left=%0d exp=0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single_vector();
      test_order();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_drain();
      test_stall_last();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
